fp_index_vector_assembler: RTL and testbench



---
 rtl/fp_index_vector_assembler_if.sv | 33 +++
 rtl/fp_index_vector_assembler.sv | 157 +++++++++++++++
 tb/tb_fp_index_vector_assembler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fp_index_vector_assembler_if.sv
// Index-stream input and assembled-frame output bundle for fp_index_vector_assembler.
// master = producer of indices / consumer of frames; slave = the assembler.
interface fp_index_vector_assembler_if #(
  parameter int unsigned LEN = 32
);
  localparam int unsigned IdxW = $clog2(LEN);
  localparam int unsigned CntW = $clog2(LEN + 1);

  logic            idx_valid;
  logic            idx_ready;
  logic [IdxW-1:0] idx;
  logic            idx_empty;
  logic            idx_last;

  logic            vec_valid;
  logic            vec_ready;
  logic [LEN-1:0]  vec;
  logic [IdxW-1:0] first_one;
  logic            no_ones;
  logic [CntW-1:0] count;
  logic            dup;
  logic            range_err;

  modport master (
    output idx_valid, idx, idx_empty, idx_last, vec_ready,
    input  idx_ready, vec_valid, vec, first_one, no_ones, count, dup, range_err
  );

  modport slave (
    input  idx_valid, idx, idx_empty, idx_last, vec_ready,
    output idx_ready, vec_valid, vec, first_one, no_ones, count, dup, range_err
  );
endinterface

// File: rtl/fp_index_vector_assembler.sv
// Rebuilds a LEN-bit vector from MSB-first bit indices (index j -> bit LEN-1-j),
// double-buffered: accumulator plus output register with per-frame summary flags.
module fp_index_vector_assembler #(
  parameter int unsigned LEN = 32
) (
  input  logic clk_i,
  input  logic rst_ni,
  fp_index_vector_assembler_if.slave bus
);
  localparam int unsigned IdxW = $clog2(LEN);
  localparam int unsigned CntW = $clog2(LEN + 1);
  localparam logic [IdxW:0] LenW = (IdxW + 1)'(LEN);

  typedef enum logic {ACCUM, WAIT} state_e;
  state_e state_q, state_d;

  logic [LEN-1:0]  acc_vec;
  logic [IdxW-1:0] acc_min;
  logic [CntW-1:0] acc_cnt;
  logic            acc_dup, acc_rng;

  logic [LEN-1:0]  nxt_vec;
  logic [IdxW-1:0] nxt_min;
  logic [CntW-1:0] nxt_cnt;
  logic            nxt_dup, nxt_rng;

  logic [LEN-1:0]  out_vec;
  logic [IdxW-1:0] out_first;
  logic [CntW-1:0] out_cnt;
  logic            out_none, out_dup, out_rng, out_valid;

  logic [LEN-1:0]  mask;
  logic            in_range, hit, new_bit, beat_fire, out_free;
  logic            load_nxt, load_acc, acc_clr, acc_upd;

  assign beat_fire = bus.idx_valid && bus.idx_ready;
  assign out_free  = !out_valid || bus.vec_ready;
  assign in_range  = {1'b0, bus.idx} < LenW;

  // Accumulator contents including the beat on the bus this cycle.
  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < LEN; b++) begin
      if (in_range && (bus.idx == IdxW'(LEN - 1 - b))) mask[b] = 1'b1;
    end
    hit     = |(acc_vec & mask);
    new_bit = (|mask) && !hit;
    nxt_vec = acc_vec;
    nxt_min = acc_min;
    nxt_cnt = acc_cnt;
    nxt_dup = acc_dup;
    nxt_rng = acc_rng;
    if (beat_fire && !bus.idx_empty) begin
      nxt_vec = acc_vec | mask;
      nxt_cnt = acc_cnt + CntW'(new_bit);
      nxt_dup = acc_dup | hit;
      nxt_rng = acc_rng | !in_range;
      if (new_bit && ((acc_cnt == '0) || (bus.idx < acc_min))) nxt_min = bus.idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_nxt      = 1'b0;
    load_acc      = 1'b0;
    acc_clr       = 1'b0;
    acc_upd       = 1'b0;
    bus.idx_ready = 1'b0;
    case (state_q)
      ACCUM: begin
        bus.idx_ready = rst_ni;
        if (beat_fire) begin
          if (bus.idx_last && out_free) begin
            load_nxt = 1'b1;
            acc_clr  = 1'b1;
          end else begin
            acc_upd = 1'b1;
            if (bus.idx_last) state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.vec_ready) begin
          load_acc = 1'b1;
          acc_clr  = 1'b1;
          state_d  = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_vec   <= '0;
      acc_min   <= '0;
      acc_cnt   <= '0;
      acc_dup   <= 1'b0;
      acc_rng   <= 1'b0;
      out_vec   <= '0;
      out_first <= '0;
      out_cnt   <= '0;
      out_none  <= 1'b0;
      out_dup   <= 1'b0;
      out_rng   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (acc_clr) begin
        acc_vec <= '0;
        acc_min <= '0;
        acc_cnt <= '0;
        acc_dup <= 1'b0;
        acc_rng <= 1'b0;
      end else if (acc_upd) begin
        acc_vec <= nxt_vec;
        acc_min <= nxt_min;
        acc_cnt <= nxt_cnt;
        acc_dup <= nxt_dup;
        acc_rng <= nxt_rng;
      end

      // A new load keeps valid high even when the current frame is consumed.
      if (load_nxt) begin
        out_vec   <= nxt_vec;
        out_first <= nxt_min;
        out_cnt   <= nxt_cnt;
        out_none  <= (nxt_cnt == '0);
        out_dup   <= nxt_dup;
        out_rng   <= nxt_rng;
        out_valid <= 1'b1;
      end else if (load_acc) begin
        out_vec   <= acc_vec;
        out_first <= acc_min;
        out_cnt   <= acc_cnt;
        out_none  <= (acc_cnt == '0);
        out_dup   <= acc_dup;
        out_rng   <= acc_rng;
        out_valid <= 1'b1;
      end else if (out_valid && bus.vec_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.vec_valid = out_valid;
  assign bus.vec       = out_vec;
  assign bus.first_one = out_first;
  assign bus.no_ones   = out_none;
  assign bus.count     = out_cnt;
  assign bus.dup       = out_dup;
  assign bus.range_err = out_rng;
endmodule

// File: tb/tb_fp_index_vector_assembler.sv
// Directed bench for fp_index_vector_assembler at LEN=32 and LEN=24.
module tb_fp_index_vector_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  fp_index_vector_assembler_if #(.LEN(32)) b32 ();
  fp_index_vector_assembler_if #(.LEN(24)) b24 ();

  fp_index_vector_assembler #(.LEN(32)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32));
  fp_index_vector_assembler #(.LEN(24)) dut24 (.clk_i(clk), .rst_ni(rst_n), .bus(b24));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic beat(input int sel, input int idx, input bit empty, input bit last);
    int n = 0;
    if (sel == 0) begin
      b32.idx = 5'(idx); b32.idx_empty = empty; b32.idx_last = last; b32.idx_valid = 1'b1;
      while (!b32.idx_ready && n < 20) begin tick(); n++; end
    end else begin
      b24.idx = 5'(idx); b24.idx_empty = empty; b24.idx_last = last; b24.idx_valid = 1'b1;
      while (!b24.idx_ready && n < 20) begin tick(); n++; end
    end
    if (n >= 20) check("beat_timeout", 32'(n), 32'd0);
    tick();
    b32.idx_valid = 1'b0;
    b24.idx_valid = 1'b0;
  endtask

  initial begin
    b32.idx_valid = 1'b0; b32.idx = '0; b32.idx_empty = 1'b0; b32.idx_last = 1'b0; b32.vec_ready = 1'b1;
    b24.idx_valid = 1'b0; b24.idx = '0; b24.idx_empty = 1'b0; b24.idx_last = 1'b0; b24.vec_ready = 1'b1;
    tick(); tick();
    check("rst_idx_ready", 32'(b32.idx_ready), 32'd0);
    check("rst_vec_valid", 32'(b32.vec_valid), 32'd0);
    check("rst_vec", b32.vec, 32'h0);
    check("rst_no_ones", 32'(b32.no_ones), 32'd0);
    check("rst_count", 32'(b32.count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_idx_ready", 32'(b32.idx_ready), 32'd1);

    // 1: indices 5, 2, 9
    beat(0, 5, 1'b0, 1'b0);
    beat(0, 2, 1'b0, 1'b0);
    check("t1_not_yet_valid", 32'(b32.vec_valid), 32'd0);
    beat(0, 9, 1'b0, 1'b1);
    check("t1_valid", 32'(b32.vec_valid), 32'd1);
    check("t1_vec", b32.vec, 32'h24400000);
    check("t1_first", 32'(b32.first_one), 32'd2);
    check("t1_count", 32'(b32.count), 32'd3);
    check("t1_no_ones", 32'(b32.no_ones), 32'd0);
    check("t1_dup", 32'(b32.dup), 32'd0);

    // 2: empty single-beat frame, back-to-back with frame 1 draining
    beat(0, 0, 1'b1, 1'b1);
    check("t2_valid", 32'(b32.vec_valid), 32'd1);
    check("t2_vec", b32.vec, 32'h0);
    check("t2_no_ones", 32'(b32.no_ones), 32'd1);
    check("t2_first", 32'(b32.first_one), 32'd0);
    check("t2_count", 32'(b32.count), 32'd0);
    tick();
    check("t2_drained", 32'(b32.vec_valid), 32'd0);

    // 3: backpressure, second frame parks in the accumulator
    b32.vec_ready = 1'b0;
    beat(0, 0, 1'b0, 1'b1);
    check("t3a_vec", b32.vec, 32'h80000000);
    beat(0, 31, 1'b0, 1'b1);
    check("t3_wait_ready", 32'(b32.idx_ready), 32'd0);
    check("t3_hold_vec", b32.vec, 32'h80000000);
    tick();
    check("t3_stable_vec", b32.vec, 32'h80000000);
    check("t3_stable_valid", 32'(b32.vec_valid), 32'd1);
    b32.vec_ready = 1'b1;
    tick();
    check("t3b_vec", b32.vec, 32'h00000001);
    check("t3b_valid", 32'(b32.vec_valid), 32'd1);
    check("t3b_idx_ready", 32'(b32.idx_ready), 32'd1);
    check("t3b_first", 32'(b32.first_one), 32'd31);
    tick();
    check("t3_drained", 32'(b32.vec_valid), 32'd0);

    // 4: duplicate index
    beat(0, 7, 1'b0, 1'b0);
    beat(0, 7, 1'b0, 1'b1);
    check("t4_vec", b32.vec, 32'h01000000);
    check("t4_count", 32'(b32.count), 32'd1);
    check("t4_dup", 32'(b32.dup), 32'd1);
    check("t4_range", 32'(b32.range_err), 32'd0);
    tick();

    // 5: out-of-range index on LEN=24
    beat(1, 30, 1'b0, 1'b0);
    beat(1, 0, 1'b0, 1'b1);
    check("t5_valid", 32'(b24.vec_valid), 32'd1);
    check("t5_vec", 32'(b24.vec), 32'h00800000);
    check("t5_range", 32'(b24.range_err), 32'd1);
    check("t5_count", 32'(b24.count), 32'd1);
    check("t5_first", 32'(b24.first_one), 32'd0);
    tick();

    // 6: reset discards a partial frame
    beat(0, 3, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("t6_rst_ready", 32'(b32.idx_ready), 32'd0);
    check("t6_rst_valid", 32'(b32.vec_valid), 32'd0);
    rst_n = 1'b1;
    beat(0, 4, 1'b0, 1'b1);
    check("t6_vec", b32.vec, 32'h08000000);
    check("t6_count", 32'(b32.count), 32'd1);
    check("t6_first", 32'(b32.first_one), 32'd4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
